// File: rtl/oai_pipe.sv
// Pipelined OAI/OA lanes feeding a 2-entry elastic valid/ready output buffer.
// Only the per-lane results are stored; the inputs are consumed at the push edge.
module oai_pipe #(
  parameter int WIDTH = 4,
  parameter int N_AND = 2,
  parameter int N_OR  = 2,
  parameter int CNT_W = 8
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [WIDTH*N_AND-1:0] A,
  input  logic [WIDTH*N_OR-1:0]  C,
  input  logic                   INV,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  output logic [WIDTH-1:0]       Y,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [CNT_W-1:0]       TXN_CNT
);

  logic [WIDTH-1:0] res;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic term;
    assign term   = (&A[i*N_AND +: N_AND]) & (|C[i*N_OR +: N_OR]);
    assign res[i] = INV ? ~term : term;
  end

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic             head_q, head_d;
  logic [1:0]       count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] txn_q, txn_d;

  logic push, pop, tail;

  assign push = IN_VALID & in_ready_q;
  assign pop  = (count_q != 2'd0) & OUT_READY;
  // With one entry the free slot is the other one; when empty, the head slot is reused.
  assign tail = head_q ^ (count_q == 2'd1);

  always_comb begin
    slot0_d    = slot0_q;
    slot1_d    = slot1_q;
    head_d     = head_q;
    count_d    = count_q;
    txn_d      = txn_q;

    if (push) begin
      if (tail) slot1_d = res;
      else      slot0_d = res;
    end

    // Head only moves when another entry remains, so Y holds its value once drained.
    if (pop && ((count_q == 2'd2) || push)) head_d = ~head_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (pop) txn_d = txn_q + CNT_W'(1);

    in_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slot0_q    <= '0;
      slot1_q    <= '0;
      head_q     <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
      txn_q      <= '0;
    end else begin
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      head_q     <= head_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      txn_q      <= txn_d;
    end
  end

  assign Y         = head_q ? slot1_q : slot0_q;
  assign OUT_VALID = (count_q != 2'd0);
  assign IN_READY  = in_ready_q;
  assign TXN_CNT   = txn_q;

endmodule

// File: tb/tb_oai_pipe.sv
// Self-checking bench for oai_pipe: queue-based reference model, directed and random traffic,
// plus instances for counter wrap (CNT_W=2) and a single-lane N_AND=1/N_OR=3 corner.
module tb_oai_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default instance
  logic [7:0] a = '0, c = '0;
  logic       inv = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_valid;
  logic [3:0] y;
  logic [7:0] txn_cnt;

  oai_pipe dut (
    .CLK(clk), .RST_N(rst_n), .A(a), .C(c), .INV(inv), .IN_VALID(in_valid),
    .IN_READY(in_ready), .Y(y), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .TXN_CNT(txn_cnt)
  );

  // counter-wrap instance
  logic [7:0] a2 = 8'hFF, c2 = 8'hFF;
  logic       inv2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic       in_ready2, out_valid2;
  logic [3:0] y2;
  logic [1:0] txn_cnt2;

  oai_pipe #(.CNT_W(2)) dut2 (
    .CLK(clk), .RST_N(rst_n), .A(a2), .C(c2), .INV(inv2), .IN_VALID(in_valid2),
    .IN_READY(in_ready2), .Y(y2), .OUT_VALID(out_valid2), .OUT_READY(out_ready2),
    .TXN_CNT(txn_cnt2)
  );

  // single-lane corner instance
  logic       a3 = 1'b0;
  logic [2:0] c3 = '0;
  logic       inv3 = 1'b1, in_valid3 = 1'b0, out_ready3 = 1'b0;
  logic       in_ready3, out_valid3;
  logic [0:0] y3;
  logic [7:0] txn_cnt3;

  oai_pipe #(.WIDTH(1), .N_AND(1), .N_OR(3)) dut3 (
    .CLK(clk), .RST_N(rst_n), .A(a3), .C(c3), .INV(inv3), .IN_VALID(in_valid3),
    .IN_READY(in_ready3), .Y(y3), .OUT_VALID(out_valid3), .OUT_READY(out_ready3),
    .TXN_CNT(txn_cnt3)
  );

  // reference model for the default instance
  logic [3:0] q[$];
  logic [7:0] txn_m = '0;

  function automatic logic [3:0] ref_y(input logic [7:0] av, input logic [7:0] cv, input logic iv);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      int  and_in, or_in;
      bit  t;
      and_in = (av >> (2 * i)) % 4;
      or_in  = (cv >> (2 * i)) % 4;
      t      = (and_in == 3) && (or_in != 0);
      r[i]   = iv ? !t : t;
    end
    return r;
  endfunction

  task automatic check_state(input string tag);
    checks++;
    assert (out_valid === (q.size() > 0))
    else begin errors++; $error("FAIL %s out_valid got %b want %b", tag, out_valid, q.size() > 0); end
    checks++;
    assert (in_ready === (q.size() < 2))
    else begin errors++; $error("FAIL %s in_ready got %b want %b", tag, in_ready, q.size() < 2); end
    checks++;
    assert (txn_cnt === txn_m)
    else begin errors++; $error("FAIL %s txn_cnt got %0d want %0d", tag, txn_cnt, txn_m); end
    if (q.size() > 0) begin
      checks++;
      assert (y === q[0])
      else begin errors++; $error("FAIL %s y got %h want %h", tag, y, q[0]); end
    end
  endtask

  // one clock with the currently driven inputs, then model update and check
  task automatic step(input string tag);
    bit push, pop;
    logic [3:0] r;
    push = in_valid && (q.size() < 2);
    pop  = (q.size() > 0) && out_ready;
    r    = ref_y(a, c, inv);
    @(posedge clk);
    if (pop) begin
      void'(q.pop_front());
      txn_m++;
    end
    if (push) q.push_back(r);
    #1;
    check_state(tag);
  endtask

  initial begin
    logic [7:0] sa[6], sc[6];
    bit         pat[6];
    int         pushed, cyc;
    logic [1:0] cnt2_m;
    int         occ2;

    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // reset release, then fill two entries and reset mid-stream
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check_state("idle_after_reset");
    in_valid = 1'b1; inv = 1'b0; out_ready = 1'b0;
    a = 8'h03; c = 8'h01; step("fill0");
    a = 8'h0C; c = 8'h04; step("fill1");
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    txn_m = '0;
    checks++;
    assert (y === 4'h0) else begin errors++; $error("FAIL async_rst y got %h want 0", y); end
    check_state("async_rst");
    #5 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("idle_post_release");
      checks++;
      assert (y === 4'h0) else begin errors++; $error("FAIL idle_y got %h want 0", y); end
    end

    // backpressure: three offered, two accepted, drained in order
    inv = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    a = 8'h03; c = 8'h01; step("bp_push1");
    a = 8'h0C; c = 8'h04; step("bp_push2");
    checks++;
    assert (in_ready === 1'b0) else begin errors++; $error("FAIL bp_full in_ready got %b want 0", in_ready); end
    a = 8'h0F; c = 8'h05; step("bp_push3_blocked");
    step("bp_hold");
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    assert (y === 4'h1) else begin errors++; $error("FAIL bp_head y got %h want 1", y); end
    step("bp_drain1");
    checks++;
    assert (y === 4'h2) else begin errors++; $error("FAIL bp_second y got %h want 2", y); end
    step("bp_drain2");
    checks++;
    assert (txn_cnt === 8'd2) else begin errors++; $error("FAIL bp_txn got %0d want 2", txn_cnt); end

    // truth table of lane 0, inverted, other lanes A=0
    inv = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic [3:0] v;
      v = k[3:0];
      a = {6'b0, v[3:2]};
      c = {6'b0, v[1:0]};
      step("truth");
      checks++;
      assert (y === {3'b111, !(v[3:2] == 2'b11 && v[1:0] != 2'b00)})
      else begin errors++; $error("FAIL truth_k%0d y got %h", k, y); end
    end

    // non-inverted, all lanes true, then lane 2 OR group cleared
    inv = 1'b0; a = 8'hFF; c = 8'b0101_0101; step("oa_all");
    checks++;
    assert (y === 4'b1111) else begin errors++; $error("FAIL oa_all y got %b want 1111", y); end
    c = 8'b0100_0101; step("oa_lane2");
    checks++;
    assert (y === 4'b1011) else begin errors++; $error("FAIL oa_lane2 y got %b want 1011", y); end
    in_valid = 1'b0; step("oa_drain");

    // six back-to-back transactions with toggling OUT_READY
    for (int i = 0; i < 6; i++) begin
      sa[i] = 8'($urandom);
      sc[i] = 8'($urandom);
    end
    pushed = 0; cyc = 0; inv = 1'b1;
    while (pushed < 6 && cyc < 40) begin
      bit acc;
      out_ready = pat[cyc % 6];
      in_valid = 1'b1; a = sa[pushed]; c = sc[pushed];
      acc = (q.size() < 2);
      step("stream");
      if (acc) pushed++;
      cyc++;
    end
    checks++;
    assert (pushed == 6) else begin errors++; $error("FAIL stream_timeout pushed %0d want 6", pushed); end
    in_valid = 1'b0; out_ready = 1'b1;
    step("stream_drain1"); step("stream_drain2");

    // random traffic
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      a = 8'($urandom); c = 8'($urandom); inv = 1'($urandom);
      step("random");
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step("rand_drain1"); step("rand_drain2");

    // counter wrap on CNT_W=2 instance
    in_valid2 = 1'b1; out_ready2 = 1'b1;
    cnt2_m = '0; occ2 = 0;
    for (int i = 0; i < 6; i++) begin
      bit pop2;
      pop2 = (occ2 > 0);
      @(posedge clk);
      if (pop2) cnt2_m = cnt2_m + 2'd1;
      occ2 = occ2 + 1 - (pop2 ? 1 : 0);
      #1;
      checks++;
      assert (txn_cnt2 === cnt2_m)
      else begin errors++; $error("FAIL wrap_%0d txn got %0d want %0d", i, txn_cnt2, cnt2_m); end
    end
    in_valid2 = 1'b0;

    // single-lane corner: N_AND=1, N_OR=3, inverted
    in_valid3 = 1'b1; out_ready3 = 1'b1; inv3 = 1'b1; a3 = 1'b1;
    c3 = 3'b100;
    @(posedge clk); #1;
    checks++;
    assert (out_valid3 === 1'b1 && y3 === 1'b0)
    else begin errors++; $error("FAIL corner_c100 v/y got %b%b want 10", out_valid3, y3); end
    c3 = 3'b000;
    @(posedge clk); #1;
    checks++;
    assert (out_valid3 === 1'b1 && y3 === 1'b1)
    else begin errors++; $error("FAIL corner_c000 v/y got %b%b want 11", out_valid3, y3); end
    in_valid3 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
